word_assembler: RTL



---
 rtl/asm_pkg.sv | 18 +
 rtl/asm_ctrl.sv | 111 +++++++++++
 rtl/word_assembler.sv | 72 +++++++
 3 files changed

// File: rtl/asm_pkg.sv
// Shared types and default geometry for the word assembler.
// Latency: n/a (package only).
// Backpressure: n/a.
package asm_pkg;

  // Default geometry: four byte beats per 32-bit word.
  localparam int DEF_WORD_W = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int BEATS      = DEF_WORD_W / DEF_BYTE_W;
  localparam int CNT_W      = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } asm_state_t;

endpackage

// File: rtl/asm_ctrl.sv
// Sequencing for the word assembler: FSM, beat counter, byte-lane write enables.
// Latency: out_load is combinational from the registered DONE state.
// Backpressure: in_ready drops outside COLLECT; out_hold parks the FSM in DONE.
//
// Ports: clk/rst (async active-low), clr (sync flush), in_valid, out_hold,
//        beat_bad (parity of the current byte, ASM_PARITY_EN only),
//        in_ready, out_load, lane_we (one-hot per accepted beat),
//        par_err (dropped-word pulse, ASM_PARITY_EN only).
// Optional feature macro: ASM_PARITY_EN.
module asm_ctrl
  import asm_pkg::*;
#(
  parameter int N_BEATS = BEATS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  input  logic               out_hold,
`ifdef ASM_PARITY_EN
  input  logic               beat_bad,
  output logic               par_err,
`endif
  output logic               in_ready,
  output logic               out_load,
  output logic [N_BEATS-1:0] lane_we
);

  localparam int CW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  asm_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          release_word;

`ifdef ASM_PARITY_EN
  logic flag_q, flag_d;
`endif

  // clr wins over everything except reset, so both handshakes are masked by it.
  assign in_ready     = (state_q == COLLECT) && !clr;
  assign accept       = in_valid && in_ready;
  assign release_word = (state_q == DONE) && !out_hold && !clr;
  assign lane_we      = accept ? (N_BEATS'(1) << cnt_q) : '0;

`ifdef ASM_PARITY_EN
  // A corrupted word leaves DONE through par_err instead of out_load.
  assign out_load = release_word && !flag_q;
  assign par_err  = release_word && flag_q;
`else
  assign out_load = release_word;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef ASM_PARITY_EN
    flag_d  = flag_q;
`endif
    if (clr) begin
      state_d = COLLECT;
      cnt_d   = '0;
`ifdef ASM_PARITY_EN
      flag_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = COLLECT;
        COLLECT: begin
          if (accept) begin
`ifdef ASM_PARITY_EN
            flag_d = flag_q | beat_bad;
`endif
            if (cnt_q == CW'(N_BEATS - 1)) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (!out_hold) begin
            state_d = COLLECT;
`ifdef ASM_PARITY_EN
            flag_d  = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef ASM_PARITY_EN
      flag_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef ASM_PARITY_EN
      flag_q  <= flag_d;
`endif
    end
  end

endmodule

// File: rtl/word_assembler.sv
// Packs BEATS little-endian bytes from a ready/valid source into one word with a load strobe.
// Latency: out_load rises the cycle after the last beat is accepted (when out_hold=0).
// Backpressure: in_ready=0 outside COLLECT; out_hold stalls the load and freezes out_data.
//
// Ports: clk, rst (async active-low), clr (sync flush of partial/pending word),
//        in_valid/in_byte/in_ready (byte source), out_hold (consumer stall),
//        out_data/out_load (word and one-cycle loadEnable),
//        in_par/par_err (even parity in, dropped-word pulse out; ASM_PARITY_EN only).
// Optional feature macro: ASM_PARITY_EN.
module word_assembler
  import asm_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  input  logic              out_hold,
  output logic [WORD_W-1:0] out_data,
  output logic              out_load,
`ifdef ASM_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic              unused_tie_lo
);

  localparam int N_BEATS = WORD_W / BYTE_W;

  logic [N_BEATS-1:0] lane_we;
  logic [WORD_W-1:0]  out_data_q, out_data_d;

  assign unused_tie_lo = 1'b0;

  asm_ctrl #(
    .N_BEATS (N_BEATS)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .out_hold (out_hold),
`ifdef ASM_PARITY_EN
    .beat_bad (^{in_byte, in_par}),
    .par_err  (par_err),
`endif
    .in_ready (in_ready),
    .out_load (out_load),
    .lane_we  (lane_we)
  );

  // Lanes are written in place, so out_data only changes once the next word's
  // beat 0 lands; clr deliberately leaves it alone.
  always_comb begin
    out_data_d = out_data_q;
    for (int k = 0; k < N_BEATS; k++) begin
      if (lane_we[k]) out_data_d[k*BYTE_W +: BYTE_W] = in_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_data_q <= '0;
    else      out_data_q <= out_data_d;
  end

  assign out_data = out_data_q;

endmodule
